// File: rtl/c7bbiu_wr_ctrl.sv
// BIU write-channel controller: arbitrates single-beat 64-bit writes from the
// LSU and debug requesters, latches the winner, drives AXI AW and W
// independently until both handshake, caps writes awaiting a B response and
// routes each B response back to its requester by AXI ID.
module c7bbiu_wr_ctrl #(
    parameter logic [3:0] ID_LSU    = 4'h1,
    parameter logic [3:0] ID_DBG    = 4'h2,
    parameter int         MAX_OUTST = 2,
    parameter logic [2:0] AW_SIZE   = 3'b011
) (
    input  logic        clk,
    input  logic        resetn,
    // LSU requester
    input  logic        lsu_biu_wr_req,
    input  logic [31:0] lsu_biu_wr_addr,
    input  logic [63:0] lsu_biu_wr_data,
    input  logic [7:0]  lsu_biu_wr_strb,
    output logic        biu_lsu_wr_ack,
    output logic        biu_lsu_wr_done,
    // debug requester
    input  logic        dbg_biu_wr_req,
    input  logic [31:0] dbg_biu_wr_addr,
    input  logic [63:0] dbg_biu_wr_data,
    input  logic [7:0]  dbg_biu_wr_strb,
    output logic        biu_dbg_wr_ack,
    output logic        biu_dbg_wr_done,
    output logic [1:0]  biu_wr_resp,
    // AXI write address channel
    output logic        axi_aw_valid,
    input  logic        axi_aw_ready,
    output logic [3:0]  axi_aw_id,
    output logic [31:0] axi_aw_addr,
    output logic [7:0]  axi_aw_len,
    output logic [2:0]  axi_aw_size,
    output logic [1:0]  axi_aw_burst,
    // AXI write data channel
    output logic        axi_w_valid,
    input  logic        axi_w_ready,
    output logic [63:0] axi_w_data,
    output logic [7:0]  axi_w_strb,
    output logic        axi_w_last,
    // AXI write response channel
    input  logic        axi_b_valid,
    output logic        axi_b_ready,
    input  logic [3:0]  axi_b_id,
    input  logic [1:0]  axi_b_resp
);

    localparam int                 CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             aw_pend_reg, aw_pend_next;
    logic             w_pend_reg, w_pend_next;
    logic             last_dbg_reg, last_dbg_next;   // 1: most recent grant went to DBG
    logic [CNT_W-1:0] outst_cnt_reg, outst_cnt_next;
    logic [3:0]       id_reg;
    logic [31:0]      addr_reg;
    logic [63:0]      data_reg;
    logic [7:0]       strb_reg;
    logic             b_ready_reg;

    logic             b_take;
    logic             slot_free;
    logic             grant_lsu;
    logic             grant_dbg;
    logic             grant;

    // A B beat only counts while something is outstanding; a counted B frees
    // its slot for a grant in the very same cycle.
    assign b_take    = axi_b_valid & b_ready_reg & (outst_cnt_reg != '0);
    assign slot_free = (outst_cnt_reg < CNT_MAX) | b_take;
    assign grant     = grant_lsu | grant_dbg;

    // State and pending-channel registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            aw_pend_reg  <= 1'b0;
            w_pend_reg   <= 1'b0;
            last_dbg_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            aw_pend_reg  <= aw_pend_next;
            w_pend_reg   <= w_pend_next;
            last_dbg_reg <= last_dbg_next;
        end
    end

    // Next state: arbitrate in IDLE, retire AW and W independently in SEND
    always_comb begin
        state_next    = state_reg;
        aw_pend_next  = aw_pend_reg;
        w_pend_next   = w_pend_reg;
        last_dbg_next = last_dbg_reg;
        grant_lsu     = 1'b0;
        grant_dbg     = 1'b0;
        case (state_reg)
            IDLE: begin
                // resetn gating keeps the combinational ack quiet while in reset
                if (resetn && slot_free) begin
                    if (lsu_biu_wr_req && (!dbg_biu_wr_req || last_dbg_reg)) begin
                        grant_lsu = 1'b1;
                    end else if (dbg_biu_wr_req) begin
                        grant_dbg = 1'b1;
                    end
                end
                if (grant_lsu || grant_dbg) begin
                    aw_pend_next  = 1'b1;
                    w_pend_next   = 1'b1;
                    last_dbg_next = grant_dbg;
                    state_next    = SEND;
                end
            end
            SEND: begin
                if (aw_pend_reg && axi_aw_ready) begin
                    aw_pend_next = 1'b0;
                end
                if (w_pend_reg && axi_w_ready) begin
                    w_pend_next = 1'b0;
                end
                if (!aw_pend_next && !w_pend_next) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outstanding-write counter: a grant and a counted B in one cycle cancel
    always_comb begin
        outst_cnt_next = outst_cnt_reg;
        case ({grant, b_take})
            2'b10:   outst_cnt_next = outst_cnt_reg + CNT_ONE;
            2'b01:   outst_cnt_next = outst_cnt_reg - CNT_ONE;
            default: outst_cnt_next = outst_cnt_reg;
        endcase
    end

    // Counter and B-ready registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outst_cnt_reg <= '0;
            b_ready_reg   <= 1'b0;
        end else begin
            outst_cnt_reg <= outst_cnt_next;
            b_ready_reg   <= 1'b1;
        end
    end

    // Latch the winning request's payload; held stable until the next grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_reg   <= '0;
            addr_reg <= '0;
            data_reg <= '0;
            strb_reg <= '0;
        end else if (grant_lsu) begin
            id_reg   <= ID_LSU;
            addr_reg <= lsu_biu_wr_addr;
            data_reg <= lsu_biu_wr_data;
            strb_reg <= lsu_biu_wr_strb;
        end else if (grant_dbg) begin
            id_reg   <= ID_DBG;
            addr_reg <= dbg_biu_wr_addr;
            data_reg <= dbg_biu_wr_data;
            strb_reg <= dbg_biu_wr_strb;
        end
    end

    assign biu_lsu_wr_ack  = grant_lsu;
    assign biu_dbg_wr_ack  = grant_dbg;
    assign biu_lsu_wr_done = b_take & (axi_b_id == ID_LSU);
    assign biu_dbg_wr_done = b_take & (axi_b_id == ID_DBG);
    assign biu_wr_resp     = (biu_lsu_wr_done | biu_dbg_wr_done) ? axi_b_resp : 2'b00;

    assign axi_aw_valid = aw_pend_reg;
    assign axi_aw_id    = id_reg;
    assign axi_aw_addr  = addr_reg;
    assign axi_aw_len   = 8'h00;
    assign axi_aw_size  = AW_SIZE;
    assign axi_aw_burst = 2'b01;

    assign axi_w_valid  = w_pend_reg;
    assign axi_w_data   = data_reg;
    assign axi_w_strb   = strb_reg;
    assign axi_w_last   = w_pend_reg;

    assign axi_b_ready  = b_ready_reg;

endmodule
